// File: rtl/target_pkg.sv
// Shared encodings for the I3C target HDR-DDR control engine.
package target_pkg;

  // Engine states
  typedef logic [2:0] state_t;
  localparam state_t S_SDR   = 3'd0;
  localparam state_t S_PRE   = 3'd1;
  localparam state_t S_NT    = 3'd2;
  localparam state_t S_CCC   = 3'd3;
  localparam state_t S_ABORT = 3'd4;

  // Decoded word types from the receiver
  localparam logic [1:0] DEC_CMD  = 2'd0;
  localparam logic [1:0] DEC_DATA = 2'd1;
  localparam logic [1:0] DEC_CRC  = 2'd2;
  localparam logic [1:0] DEC_ERR  = 2'd3;

  // Receiver mode codes; cast to MODE_W at the point of use
  localparam int unsigned MODE_IDLE     = 0;
  localparam int unsigned MODE_PREAMBLE = 1;
  localparam int unsigned MODE_DATA     = 3;
  localparam int unsigned MODE_ABORT    = 5;

endpackage

// File: rtl/target_watchdog.sv
// Bus-inactivity watchdog: counts cycles while running, expires at TIMEOUT_CYC-1.
module target_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry depends only on the registered count so the engine's next-state
  // logic can feed the clear input without forming a loop.
  assign o_expire = i_run && (cnt_q == LAST);

  // Count while running, saturating at the expiry value
  always_comb begin
    cnt_d = cnt_q;
    if (!i_run || i_clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/target_hdr_engine.sv
// I3C target HDR-DDR control engine: ENTHDR, preamble/command dispatch to NT/CCC,
// word limit, inactivity watchdog, abort with error counting, RESTART/EXIT recovery.
module target_hdr_engine
  import target_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MODE_W      = 4,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned CNT_W       = $clog2(MAX_WORDS + 1)
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_rstdet_RESTART,
  input  logic              i_exitdet_EXIT,
  input  logic              i_ENTHDR_done,
  input  logic              i_rx_CCC_done,
  input  logic              i_rx_NT_done,
  input  logic [1:0]        i_rx_dec,
  input  logic              i_rx_dec_done,
  input  logic              i_cmd_is_ccc,
  output logic              o_ENTHDR_en,
  output logic              o_NT_en,
  output logic              o_CCC_en,
  output logic              o_rx_en,
  output logic [MODE_W-1:0] o_rx_mode,
  output logic [CNT_W-1:0]  o_word_cnt,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic              o_timeout,
  output logic              o_busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d, word_inc;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               in_hdr, is_data, wd_run, wd_clr, wd_expire, enter_abort;
  logic               ent_en_q, ent_en_d, nt_en_q, nt_en_d, ccc_en_q, ccc_en_d;
  logic               rx_en_q, rx_en_d, busy_q, busy_d, timeout_q, timeout_d;
  logic [MODE_W-1:0]  mode_q, mode_d;

  assign in_hdr  = (state_q != S_SDR);
  assign is_data = i_rx_dec_done && (i_rx_dec == DEC_DATA);
  assign wd_run  = (state_q == S_PRE) || (state_q == S_NT) || (state_q == S_CCC);
  assign wd_clr  = i_rx_dec_done || i_rstdet_RESTART || (state_d != state_q);

  target_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .i_clk    (i_sys_clk),
    .i_rst    (i_sys_rst),
    .i_run    (wd_run),
    .i_clr    (wd_clr),
    .o_expire (wd_expire)
  );

  // Next state and word counter, in priority order EXIT > RESTART > watchdog > ERR > events
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    word_inc   = word_cnt_q + CNT_W'(1);
    if (in_hdr && i_exitdet_EXIT) begin
      state_d = S_SDR;
    end else if (in_hdr && i_rstdet_RESTART) begin
      state_d    = S_PRE;
      word_cnt_d = '0;
    end else if (wd_expire) begin
      state_d = S_ABORT;
    end else if (in_hdr && i_rx_dec_done && (i_rx_dec == DEC_ERR)) begin
      state_d = S_ABORT;
    end else begin
      case (state_q)
        S_SDR: if (i_ENTHDR_done) state_d = S_PRE;
        S_PRE: begin
          if (i_rx_dec_done) begin
            if (i_rx_dec == DEC_CMD) begin
              state_d    = i_cmd_is_ccc ? S_CCC : S_NT;
              word_cnt_d = '0;
            end else begin
              state_d = S_ABORT;
            end
          end
        end
        S_NT, S_CCC: begin
          if (is_data) word_cnt_d = word_inc;
          if (is_data && (word_inc == CNT_W'(MAX_WORDS))) begin
            state_d = S_ABORT;
          end else if ((state_q == S_NT) ? i_rx_NT_done : i_rx_CCC_done) begin
            state_d = S_PRE;
          end
        end
        S_ABORT: state_d = S_ABORT;
        default: state_d = S_SDR;
      endcase
    end
  end

  // Error count and timeout flag on every entry into abort
  always_comb begin
    enter_abort = (state_d == S_ABORT) && (state_q != S_ABORT);
    err_cnt_d   = err_cnt_q;
    if (enter_abort && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    timeout_d = wd_expire && enter_abort;
  end

  // Moore outputs decoded from the current state, registered one cycle later
  always_comb begin
    ent_en_d = 1'b0;
    nt_en_d  = 1'b0;
    ccc_en_d = 1'b0;
    rx_en_d  = 1'b0;
    busy_d   = in_hdr;
    mode_d   = MODE_W'(MODE_IDLE);
    case (state_q)
      S_SDR:   ent_en_d = 1'b1;
      S_PRE:   begin rx_en_d = 1'b1; mode_d = MODE_W'(MODE_PREAMBLE); end
      S_NT:    begin nt_en_d = 1'b1; rx_en_d = 1'b1; mode_d = MODE_W'(MODE_DATA); end
      S_CCC:   begin ccc_en_d = 1'b1; rx_en_d = 1'b1; mode_d = MODE_W'(MODE_DATA); end
      S_ABORT: mode_d = MODE_W'(MODE_ABORT);
      default: mode_d = MODE_W'(MODE_IDLE);
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= S_SDR;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      ent_en_q   <= 1'b0;
      nt_en_q    <= 1'b0;
      ccc_en_q   <= 1'b0;
      rx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mode_q     <= MODE_W'(MODE_IDLE);
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ent_en_q   <= ent_en_d;
      nt_en_q    <= nt_en_d;
      ccc_en_q   <= ccc_en_d;
      rx_en_q    <= rx_en_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      mode_q     <= mode_d;
    end
  end

  assign o_ENTHDR_en = ent_en_q;
  assign o_NT_en     = nt_en_q;
  assign o_CCC_en    = ccc_en_q;
  assign o_rx_en     = rx_en_q;
  assign o_rx_mode   = mode_q;
  assign o_word_cnt  = word_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_target_hdr_engine.sv
// Self-checking bench for target_hdr_engine (MAX_WORDS=4, TIMEOUT_CYC=8, ERR_W=2).
module tb_target_hdr_engine;

  localparam int unsigned MAXW = 4;
  localparam int unsigned TOC  = 8;
  localparam int unsigned MW   = 4;
  localparam int unsigned EW   = 2;
  localparam int unsigned CW   = 3;

  logic          clk = 1'b0;
  logic          rst, restart, exit_p, enthdr, ccc_done, nt_done, dec_done, is_ccc;
  logic [1:0]    dec;
  logic          ent_en, nt_en, ccc_en, rx_en, timeout, busy;
  logic [MW-1:0] mode;
  logic [CW-1:0] word_cnt;
  logic [EW-1:0] err_cnt;

  target_hdr_engine #(
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CYC (TOC),
    .MODE_W      (MW),
    .ERR_W       (EW)
  ) dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst),
    .i_rstdet_RESTART (restart),
    .i_exitdet_EXIT   (exit_p),
    .i_ENTHDR_done    (enthdr),
    .i_rx_CCC_done    (ccc_done),
    .i_rx_NT_done     (nt_done),
    .i_rx_dec         (dec),
    .i_rx_dec_done    (dec_done),
    .i_cmd_is_ccc     (is_ccc),
    .o_ENTHDR_en      (ent_en),
    .o_NT_en          (nt_en),
    .o_CCC_en         (ccc_en),
    .o_rx_en          (rx_en),
    .o_rx_mode        (mode),
    .o_word_cnt       (word_cnt),
    .o_err_cnt        (err_cnt),
    .o_timeout        (timeout),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  // Stimulus word: {rst, restart, exit, enthdr, ccc_done, nt_done, dec_done, dec[1:0], is_ccc}
  localparam logic [9:0] IDLE   = 10'b0000000000;
  localparam logic [9:0] RST    = 10'b1000000000;
  localparam logic [9:0] RS     = 10'b0100000000;
  localparam logic [9:0] EX     = 10'b0010000000;
  localparam logic [9:0] ENT    = 10'b0001000000;
  localparam logic [9:0] CCCD   = 10'b0000100000;
  localparam logic [9:0] NTD    = 10'b0000010000;
  localparam logic [9:0] CMD_NT = 10'b0000001000;
  localparam logic [9:0] CMD_CC = 10'b0000001001;
  localparam logic [9:0] DATA   = 10'b0000001010;
  localparam logic [9:0] CRC    = 10'b0000001100;
  localparam logic [9:0] ERR    = 10'b0000001110;

  // Which state's outputs are expected to be visible
  localparam int OZ = 0, OSDR = 1, OPRE = 2, ONT = 3, OCCC = 4, OAB = 5;

  typedef struct {
    logic [14:0] vec;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Expected output vector {ent,nt,ccc,rx,mode,busy,timeout,word_cnt,err_cnt}
  function automatic logic [14:0] mk(input int o, input int wc, input int err, input bit to);
    logic ent = 0, nt = 0, ccc = 0, rx = 0, bsy = 0;
    logic [3:0] md = 4'd0;
    logic [2:0] w = wc[2:0];
    logic [1:0] e = err[1:0];
    case (o)
      OSDR: ent = 1;
      OPRE: begin rx = 1; md = 4'd1; bsy = 1; end
      ONT:  begin nt = 1; rx = 1; md = 4'd3; bsy = 1; end
      OCCC: begin ccc = 1; rx = 1; md = 4'd3; bsy = 1; end
      OAB:  begin md = 4'd5; bsy = 1; end
      default: ;
    endcase
    return {ent, nt, ccc, rx, md, bsy, to, w, e};
  endfunction

  function automatic logic [14:0] obs();
    return {ent_en, nt_en, ccc_en, rx_en, mode, busy, timeout, word_cnt, err_cnt};
  endfunction

  task automatic apply(input logic [9:0] s);
    {rst, restart, exit_p, enthdr, ccc_done, nt_done, dec_done, dec, is_ccc} = s;
  endtask

  task automatic test_reset();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{RST, RST, IDLE};
    ex = '{mk(OZ, 0, 0, 0), mk(OZ, 0, 0, 0), mk(OSDR, 0, 0, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("reset[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_nt();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{ENT, IDLE, CMD_NT, IDLE, DATA, DATA, DATA, NTD, IDLE};
    ex = '{mk(OSDR, 0, 0, 0), mk(OPRE, 0, 0, 0), mk(OPRE, 0, 0, 0), mk(ONT, 0, 0, 0),
           mk(ONT, 1, 0, 0), mk(ONT, 2, 0, 0), mk(ONT, 3, 0, 0), mk(ONT, 3, 0, 0),
           mk(OPRE, 3, 0, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("nt[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_ccc();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{CMD_CC, IDLE, IDLE, CCCD, IDLE};
    ex = '{mk(OPRE, 0, 0, 0), mk(OCCC, 0, 0, 0), mk(OCCC, 0, 0, 0), mk(OCCC, 0, 0, 0),
           mk(OPRE, 0, 0, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("ccc[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_limit();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{CMD_NT, DATA, DATA, DATA, DATA, DATA, IDLE, RS, IDLE};
    ex = '{mk(OPRE, 0, 0, 0), mk(ONT, 1, 0, 0), mk(ONT, 2, 0, 0), mk(ONT, 3, 0, 0),
           mk(ONT, 4, 1, 0), mk(OAB, 4, 1, 0), mk(OAB, 4, 1, 0), mk(OAB, 0, 1, 0),
           mk(OPRE, 0, 1, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("limit[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    // RESTART restarts the idle window, then 8 quiet cycles trip the watchdog
    st = '{RS, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, IDLE, EX, IDLE};
    ex = '{mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0),
           mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0), mk(OPRE, 0, 1, 0),
           mk(OPRE, 0, 2, 1), mk(OAB, 0, 2, 0), mk(OAB, 0, 2, 0), mk(OSDR, 0, 2, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("timeout[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_err_sat();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{ENT, DATA, RS, ERR, ERR, RS, CRC, IDLE, EX, IDLE};
    ex = '{mk(OSDR, 0, 2, 0), mk(OPRE, 0, 3, 0), mk(OAB, 0, 3, 0), mk(OPRE, 0, 3, 0),
           mk(OAB, 0, 3, 0), mk(OAB, 0, 3, 0), mk(OPRE, 0, 3, 0), mk(OAB, 0, 3, 0),
           mk(OAB, 0, 3, 0), mk(OSDR, 0, 3, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("err_sat[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    // RESTART+EXIT together in NT, then pulses that must be ignored in SDR
    st = '{ENT, CMD_NT, IDLE, RS | EX, IDLE, EX, RS | NTD | CCCD, IDLE};
    ex = '{mk(OSDR, 0, 3, 0), mk(OPRE, 0, 3, 0), mk(ONT, 0, 3, 0), mk(ONT, 0, 3, 0),
           mk(OSDR, 0, 3, 0), mk(OSDR, 0, 3, 0), mk(OSDR, 0, 3, 0), mk(OSDR, 0, 3, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("b2b[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0]  st[$];
    logic [14:0] ex[$];
    exp_t        e;
    st = '{ENT, CMD_CC, DATA, RST, IDLE};
    ex = '{mk(OSDR, 0, 3, 0), mk(OPRE, 0, 3, 0), mk(OCCC, 1, 3, 0), mk(OZ, 0, 0, 0),
           mk(OSDR, 0, 0, 0)};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb.push_back('{ex[i], $sformatf("rst_mid[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e.vec)
        $display("FAIL %s: got %b required %b", e.name, obs(), e.vec);
      else n_pass++;
    end
  endtask

  initial begin
    apply(IDLE);
    test_reset();
    test_nt();
    test_ccc();
    test_limit();
    test_timeout();
    test_err_sat();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
